// File: rtl/regfile_arb_pkg.sv
// Shared widths and types for the register-file read arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 64;

  typedef logic [ADDR_W_DEF-1:0]          reg_addr_t;
  typedef logic [DATA_W_DEF-1:0]          reg_data_t;
  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Grant selector for the read port: round-robin or fixed lowest-index priority.
// Latency: grant is combinational from req; pointer updates on the edge after a grant.
// Backpressure: caller masks req to zero when it cannot accept a grant.
//
// Ports: clk, reset (sync, active-high); req (eligible requests);
//        advance (a grant was taken this cycle); grant (one-hot); grant_idx (encoded).
// Policy macro: RDARB_ROUND_ROBIN_EN (defined = round-robin, undefined = fixed priority).
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

`ifdef RDARB_ROUND_ROBIN_EN

  logic [IDX_W-1:0] ptr;

  // Walk the candidates from farthest to nearest relative to ptr so the
  // last hit (nearest to ptr, moving upward) is the one that sticks.
  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`else

  // Lowest index wins; scanning downward lets the lowest hit overwrite.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  // No pointer state in this policy; these inputs are intentionally unused.
  logic unused_fixed;
  assign unused_fixed = &{1'b0, clk, reset, advance};

`endif

endmodule

// File: rtl/regfile_read_arbiter.sv
// Arbitrates NUM_REQ read requesters onto one shared register-file read mux.
// Latency: 1 cycle from grant (req_ready high) to resp_valid; one grant per cycle.
// Backpressure: a stalled response (resp_valid && !resp_ready) holds and blocks all grants.
//
// Ports: clk, reset (sync, active-high); req_valid/req_addr (per requester,
//        addresses packed requester 0 in the LSBs); req_ready (one-hot grant);
//        rd_sel -> shared mux, rd_data <- mux; resp_valid/resp_id/resp_data/resp_ready.
// Policy macro: RDARB_ROUND_ROBIN_EN (defined = round-robin, undefined = fixed priority).
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rd_sel,
  input  logic [DATA_W-1:0]         rd_data,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_data,
  input  logic                      resp_ready
);

  logic               stage_free;
  logic [NUM_REQ-1:0] req_elig;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;

  // The response register can take a new entry if empty or being drained now.
  assign stage_free = !resp_valid || resp_ready;
  assign req_elig   = (reset || !stage_free) ? '0 : req_valid;
  assign grant_any  = |req_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_elig),
    .advance   (grant_any),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  // Grant is one-hot, so at most one address is selected; idle drives 0.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k]) begin
        rd_sel = req_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else if (grant_any) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_idx;
      resp_data  <= rd_data;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a response scoreboard queue.
// Latency: checks grant combinationally and the response one edge later.
// Backpressure: exercises stalls via resp_ready and a reset during a stall.
module tb_regfile_read_arbiter;
  import regfile_arb_pkg::*;

  typedef struct packed {
    req_id_t   id;
    reg_data_t data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [19:0] req_addr;
  logic [3:0] req_ready;
  reg_addr_t  rd_sel;
  reg_data_t  rd_data;
  logic       resp_valid;
  req_id_t    resp_id;
  reg_data_t  resp_data;
  logic       resp_ready;

  exp_t       q[$];
  logic       m_valid = 1'b0;
  int         m_ptr = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] obs_rdy;

  always #5 clk = ~clk;

  function automatic reg_data_t mux_model(input reg_addr_t sel);
    return {32'hDEAD_BEEF, 27'd0, sel};
  endfunction

  assign rd_data = mux_model(rd_sel);

  regfile_read_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input int ptr);
    int idx;
    for (int k = 0; k < 4; k++) begin
`ifdef RDARB_ROUND_ROBIN_EN
      idx = (ptr + k) % 4;
`else
      idx = k + 0 * ptr;
`endif
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Called just after a rising edge with inputs already driven; returns at edge+1.
  task automatic run_cycle(output logic [3:0] rdy);
    int         g;
    logic       free;
    logic       was_reset;
    logic [63:0] exp_rdy;
    reg_addr_t  exp_sel;
    #3;
    free    = !m_valid || resp_ready;
    g       = (!reset && free) ? model_grant(req_valid, m_ptr) : -1;
    exp_rdy = 64'd0;
    exp_sel = '0;
    if (g >= 0) begin
      exp_rdy = 64'd1 << g;
      exp_sel = req_addr[g*5 +: 5];
    end
    rdy = req_ready;
    check("req_ready", req_ready, exp_rdy);
    check("rd_sel", rd_sel, exp_sel);
    if (g >= 0) q.push_back('{id: req_id_t'(g), data: mux_model(exp_sel)});
    @(posedge clk);
    was_reset = reset;
    if (was_reset) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      q.delete();
    end else begin
      if (m_valid && resp_ready && q.size() > 0) void'(q.pop_front());
      if (g >= 0) begin
        m_valid = 1'b1;
        m_ptr   = (g + 1) % 4;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("resp_valid", resp_valid, m_valid);
    if (was_reset) begin
      check("rst_resp_id", resp_id, 64'd0);
      check("rst_resp_data", resp_data, 64'd0);
    end else if (m_valid && q.size() > 0) begin
      check("resp_id", resp_id, q[0].id);
      check("resp_data", resp_data, q[0].data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 4'b1111;
    req_addr   = {5'd30, 5'd7, 5'd11, 5'd3};
    resp_ready = 1'b1;

    // Reset held two cycles with every requester asking.
    repeat (2) begin
      run_cycle(obs_rdy);
      check("rst_no_grant", obs_rdy, 4'b0000);
    end
    reset = 1'b0;
    run_cycle(obs_rdy);
    check("rst_first_grant", obs_rdy, 4'b0001);

    req_valid = 4'b0000;
    run_cycle(obs_rdy);

    // Single request from requester 2 at register 7.
    req_valid = 4'b0100;
    run_cycle(obs_rdy);
    check("single_gnt", obs_rdy, 4'b0100);
    check("single_valid", resp_valid, 1'b1);
    check("single_id", resp_id, 2);
    check("single_data", resp_data, 64'hDEAD_BEEF_0000_0007);
    req_valid = 4'b0000;
    run_cycle(obs_rdy);

    // Clean pointer, then all four requesters held high.
    reset     = 1'b1;
    req_valid = 4'b1111;
    run_cycle(obs_rdy);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(obs_rdy);
`ifdef RDARB_ROUND_ROBIN_EN
      check("rr_seq", obs_rdy, 4'b0001 << (i % 4));
`else
      check("fixed_all", obs_rdy, 4'b0001);
`endif
    end

    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      run_cycle(obs_rdy);
`ifndef RDARB_ROUND_ROBIN_EN
      check("fixed_gnt", obs_rdy, 4'b0010);
`endif
    end

    // Backpressure with response id 1 pending.
    req_valid = 4'b0010;
    run_cycle(obs_rdy);
    check("bp_setup", obs_rdy, 4'b0010);
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    repeat (3) begin
      run_cycle(obs_rdy);
      check("bp_no_grant", obs_rdy, 4'b0000);
      check("bp_hold_id", resp_id, 1);
      check("bp_hold_data", resp_data, 64'hDEAD_BEEF_0000_000B);
    end
    resp_ready = 1'b1;
    run_cycle(obs_rdy);
`ifdef RDARB_ROUND_ROBIN_EN
    check("bp_release", obs_rdy, 4'b0100);
`else
    check("bp_release", obs_rdy, 4'b0001);
`endif

    // Reset pulse while a response is stalled.
    resp_ready = 1'b0;
    run_cycle(obs_rdy);
    reset = 1'b1;
    run_cycle(obs_rdy);
    check("mid_rst_valid", resp_valid, 1'b0);
    reset      = 1'b0;
    resp_ready = 1'b1;
    run_cycle(obs_rdy);
    check("mid_rst_restart", obs_rdy, 4'b0001);

    req_valid = 4'b0000;
    repeat (2) run_cycle(obs_rdy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
